uart_pkt_rx_ctrl: RTL

Packet-level controller on top of the UART byte receiver. It consumes the receiver's byte strobe, data and error outputs, and hunts for a sync byte. It then assembles a framed packet (CMD, LEN, payload, checksum) into an internal buffer and presents the packet to the host logic under a valid/ack handshake. It also reports framing, length, checksum, timeout and overrun errors.

---
 rtl/uart_pkt_pkg.sv | 22 ++
 rtl/uart_pkt_buf.sv | 36 +++
 rtl/uart_pkt_rx_ctrl.sv | 203 ++++++++++++++++++++
 3 files changed

// File: rtl/uart_pkt_pkg.sv
// uart_pkt_pkg
// Shared types and constants for the UART packet receive controller:
// FSM state encoding, err_code values and the default frame sync byte.
package uart_pkt_pkg;

    typedef enum logic [2:0] {
        ST_HUNT,
        ST_CMD,
        ST_LEN,
        ST_PAYLOAD,
        ST_CHK,
        ST_HOLD
    } pkt_state_t;

    localparam logic [1:0] ERR_LINE = 2'd0;
    localparam logic [1:0] ERR_LEN  = 2'd1;
    localparam logic [1:0] ERR_CHK  = 2'd2;
    localparam logic [1:0] ERR_TMO  = 2'd3;

    localparam logic [7:0] SYNC_BYTE_DEF = 8'hA5;

endpackage

// File: rtl/uart_pkt_buf.sv
// uart_pkt_buf
// DEPTH x 8 simple dual-port payload buffer.
// Ports:
//   sys_clk, sys_rst_I         clock, async active-low reset (read register only)
//   wr_en, wr_addr, wr_data    synchronous write port
//   rd_addr, rd_data           read port, data registered (1-cycle latency)
module uart_pkt_buf #(
    parameter int DEPTH = 16,
    parameter int AW    = 4
) (
    input  logic          sys_clk,
    input  logic          sys_rst_I,
    input  logic          wr_en,
    input  logic [AW-1:0] wr_addr,
    input  logic [7:0]    wr_data,
    input  logic [AW-1:0] rd_addr,
    output logic [7:0]    rd_data
);

    logic [7:0] mem [DEPTH];

    always_ff @(posedge sys_clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    always_ff @(posedge sys_clk or negedge sys_rst_I) begin
        if (!sys_rst_I) begin
            rd_data <= 8'd0;
        end else begin
            rd_data <= mem[rd_addr];
        end
    end

endmodule

// File: rtl/uart_pkt_rx_ctrl.sv
// uart_pkt_rx_ctrl
// Packet framer on top of the UART byte receiver. Hunts for SYNC_BYTE, then
// assembles CMD, LEN, payload and checksum, holds a good packet for the host
// under a valid/ack handshake and reports line/length/checksum/timeout errors.
// Ports:
//   sys_clk, sys_rst_I                  clock, async active-low reset
//   rec_readyH, rec_dataH, recv_error   byte receiver strobe, data, framing error
//   pkt_validH, pkt_cmd, pkt_len        held packet status and header
//   pkt_rd_addr, pkt_rd_data            payload read port (1-cycle latency)
//   pkt_ackH                            host releases the held packet
//   err_pulseH, err_code                one-cycle error strobe, last error code
//   overrun_cnt                         bytes dropped while holding (saturating)
//   busy                                frame reception in progress
//
// state      | meaning
// -----------+---------------------------------------------
// ST_HUNT    | waiting for the sync byte
// ST_CMD     | waiting for the command byte
// ST_LEN     | waiting for the payload length byte
// ST_PAYLOAD | storing payload bytes into the buffer
// ST_CHK     | waiting for the checksum byte
// ST_HOLD    | good packet held until the host acks
module uart_pkt_rx_ctrl
    import uart_pkt_pkg::*;
#(
    parameter int         MAX_LEN        = 16,
    parameter logic [7:0] SYNC_BYTE      = SYNC_BYTE_DEF,
    parameter int         TIMEOUT_CYCLES = 2_000_000,
    parameter int         AW             = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1
) (
    input  logic          sys_clk,
    input  logic          sys_rst_I,
    input  logic          rec_readyH,
    input  logic [7:0]    rec_dataH,
    input  logic          recv_error,
    output logic          pkt_validH,
    output logic [7:0]    pkt_cmd,
    output logic [7:0]    pkt_len,
    input  logic [AW-1:0] pkt_rd_addr,
    output logic [7:0]    pkt_rd_data,
    input  logic          pkt_ackH,
    output logic          err_pulseH,
    output logic [1:0]    err_code,
    output logic [7:0]    overrun_cnt,
    output logic          busy
);

    localparam logic [23:0] TMO_RELOAD = 24'(TIMEOUT_CYCLES - 1);

    pkt_state_t    state, state_nxt;
    logic [7:0]    sum, sum_add;
    logic [AW-1:0] wr_idx;
    logic [23:0]   tmo_cnt;
    logic          err_now;
    logic [1:0]    err_sel;
    logic          in_frame;
    logic          byte_ok;
    logic          len_ok;
    logic          buf_we;

    assign in_frame   = (state == ST_CMD) || (state == ST_LEN) ||
                        (state == ST_PAYLOAD) || (state == ST_CHK);
    // a receiver error in the same cycle overrides the byte strobe
    assign byte_ok    = rec_readyH && !recv_error;
    assign len_ok     = int'(rec_dataH) <= MAX_LEN;
    assign sum_add    = sum + rec_dataH;
    assign buf_we     = byte_ok && (state == ST_PAYLOAD);
    assign busy       = in_frame;
    assign pkt_validH = (state == ST_HOLD);

    always_ff @(posedge sys_clk or negedge sys_rst_I) begin
        if (!sys_rst_I) begin
            state <= ST_HUNT;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        err_now   = 1'b0;
        err_sel   = ERR_LINE;
        case (state)
            ST_HUNT: begin
                if (recv_error) begin
                    err_now = 1'b1;
                end else if (rec_readyH && rec_dataH == SYNC_BYTE) begin
                    state_nxt = ST_CMD;
                end
            end
            ST_HOLD: begin
                if (pkt_ackH) begin
                    state_nxt = ST_HUNT;
                end
            end
            default: begin
                if (recv_error) begin
                    err_now   = 1'b1;
                    state_nxt = ST_HUNT;
                end else if (rec_readyH) begin
                    case (state)
                        ST_CMD: state_nxt = ST_LEN;
                        ST_LEN: begin
                            if (!len_ok) begin
                                err_now   = 1'b1;
                                err_sel   = ERR_LEN;
                                state_nxt = ST_HUNT;
                            end else if (rec_dataH == 8'd0) begin
                                state_nxt = ST_CHK;
                            end else begin
                                state_nxt = ST_PAYLOAD;
                            end
                        end
                        ST_PAYLOAD: begin
                            if (int'(wr_idx) + 1 == int'(pkt_len)) begin
                                state_nxt = ST_CHK;
                            end
                        end
                        ST_CHK: begin
                            if (sum_add == 8'd0) begin
                                state_nxt = ST_HOLD;
                            end else begin
                                err_now   = 1'b1;
                                err_sel   = ERR_CHK;
                                state_nxt = ST_HUNT;
                            end
                        end
                        default: state_nxt = ST_HUNT;
                    endcase
                end else if (tmo_cnt == 24'd0) begin
                    err_now   = 1'b1;
                    err_sel   = ERR_TMO;
                    state_nxt = ST_HUNT;
                end
            end
        endcase
    end

    always_ff @(posedge sys_clk or negedge sys_rst_I) begin
        if (!sys_rst_I) begin
            pkt_cmd     <= 8'd0;
            pkt_len     <= 8'd0;
            sum         <= 8'd0;
            wr_idx      <= '0;
            tmo_cnt     <= TMO_RELOAD;
            err_pulseH  <= 1'b0;
            err_code    <= ERR_LINE;
            overrun_cnt <= 8'd0;
        end else begin
            err_pulseH <= err_now;
            if (err_now) begin
                err_code <= err_sel;
            end

            // down-counter: every byte (including the sync byte that enters
            // ST_CMD) reloads it; terminal count 0 is the timeout
            if (rec_readyH) begin
                tmo_cnt <= TMO_RELOAD;
            end else if (in_frame && tmo_cnt != 24'd0) begin
                tmo_cnt <= tmo_cnt - 24'd1;
            end

            if (byte_ok) begin
                case (state)
                    ST_CMD: begin
                        pkt_cmd <= rec_dataH;
                        sum     <= rec_dataH;
                    end
                    ST_LEN: begin
                        sum    <= sum_add;
                        wr_idx <= '0;
                        if (len_ok) begin
                            pkt_len <= rec_dataH;
                        end
                    end
                    ST_PAYLOAD: begin
                        sum    <= sum_add;
                        wr_idx <= wr_idx + AW'(1);
                    end
                    default: ;
                endcase
            end

            if (rec_readyH && state == ST_HOLD && overrun_cnt != 8'hFF) begin
                overrun_cnt <= overrun_cnt + 8'd1;
            end
        end
    end

    uart_pkt_buf #(
        .DEPTH (MAX_LEN),
        .AW    (AW)
    ) u_buf (
        .sys_clk   (sys_clk),
        .sys_rst_I (sys_rst_I),
        .wr_en     (buf_we),
        .wr_addr   (wr_idx),
        .wr_data   (rec_dataH),
        .rd_addr   (pkt_rd_addr),
        .rd_data   (pkt_rd_data)
    );

endmodule
